// File: rtl/nn_out_collector.sv
// Captures one FRAME of fp32 results, replays it over valid/ready, then emits a max/argmax summary beat.
// Optional macro NN_OUT_RELU_EN clamps negative inputs (including -0) to +0 before storage and compare.
module nn_out_collector #(
  parameter int WIDTH = 32,
  parameter int FRAME = 9,
  parameter int IDX_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic             in_ready,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [IDX_W-1:0] out_idx,
  output logic             out_last,
  output logic             overflow
);

  typedef enum logic [1:0] {COLLECT, DRAIN, SUMMARY} state_t;

  localparam logic [IDX_W-1:0] LAST = IDX_W'(FRAME - 1);
  localparam logic [WIDTH-1:0] SIGN = {1'b1, {(WIDTH-1){1'b0}}};

  state_t           state;
  logic [WIDTH-1:0] frame_buf [FRAME];
  logic [IDX_W-1:0] wr_cnt;
  logic [IDX_W-1:0] rd_ptr;
  logic [IDX_W-1:0] rd_next;
  logic [WIDTH-1:0] max_val;
  logic [IDX_W-1:0] max_idx;
  logic             max_valid;
  logic [WIDTH-1:0] word;
  logic             take;

  // Map sign-magnitude floats onto an unsigned-comparable key; -0 folds onto +0.
  function automatic logic [WIDTH-1:0] order_key(input logic [WIDTH-1:0] w);
    logic [WIDTH-1:0] n;
    n = (w == SIGN) ? '0 : w;
    return n[WIDTH-1] ? ~n : (n ^ SIGN);
  endfunction

  always_comb begin
`ifdef NN_OUT_RELU_EN
    word = in_data[WIDTH-1] ? '0 : in_data;
`else
    word = in_data;
`endif
    take    = !max_valid || (order_key(word) > order_key(max_val));
    rd_next = rd_ptr + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= COLLECT;
      wr_cnt    <= '0;
      rd_ptr    <= '0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_idx   <= '0;
      out_last  <= 1'b0;
      overflow  <= 1'b0;
      max_valid <= 1'b0;
      max_val   <= '0;
      max_idx   <= '0;
    end else begin
      if (in_valid && state != COLLECT) overflow <= 1'b1;
      case (state)
        COLLECT: begin
          if (in_valid) begin
            frame_buf[wr_cnt] <= word;
            if (take) begin
              max_val   <= word;
              max_idx   <= wr_cnt;
              max_valid <= 1'b1;
            end
            if (wr_cnt == LAST) begin
              // First replay beat is preloaded here so out_* stay registered.
              wr_cnt    <= '0;
              state     <= DRAIN;
              in_ready  <= 1'b0;
              out_valid <= 1'b1;
              out_data  <= (LAST == '0) ? word : frame_buf[0];
              out_idx   <= '0;
            end else begin
              wr_cnt <= wr_cnt + 1'b1;
            end
          end
        end
        DRAIN: begin
          if (out_ready) begin
            if (rd_ptr == LAST) begin
              rd_ptr   <= '0;
              state    <= SUMMARY;
              out_data <= max_val;
              out_idx  <= max_idx;
              out_last <= 1'b1;
            end else begin
              rd_ptr   <= rd_next;
              out_data <= frame_buf[rd_next];
              out_idx  <= rd_next;
            end
          end
        end
        SUMMARY: begin
          if (out_ready) begin
            state     <= COLLECT;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            out_last  <= 1'b0;
            out_data  <= '0;
            out_idx   <= '0;
            max_valid <= 1'b0;
          end
        end
        default: state <= COLLECT;
      endcase
    end
  end

endmodule

// File: tb/tb_nn_out_collector.sv
// Randomized self-checking bench for nn_out_collector against a numeric max/argmax model.
// Honours NN_OUT_RELU_EN the same way as the design build.
module tb_nn_out_collector;

  localparam int WIDTH = 32;
  localparam int FRAME = 9;
  localparam int IDX_W = 4;

  logic             clk = 1'b0;
  logic             rst;
  logic             in_valid;
  logic [WIDTH-1:0] in_data;
  logic             in_ready;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;
  logic [IDX_W-1:0] out_idx;
  logic             out_last;
  logic             overflow;

  int n_tests = 0;
  int n_fail  = 0;
  logic exp_ovf = 1'b0;
  logic [31:0] frame_w [FRAME];

  nn_out_collector #(.WIDTH(WIDTH), .FRAME(FRAME), .IDX_W(IDX_W)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_idx(out_idx),
    .out_last(out_last), .overflow(overflow)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Numeric value of a finite float, scaled: magnitude bits are monotonic in |x|.
  function automatic longint fval(input logic [31:0] w);
    return w[31] ? -longint'(w[30:0]) : longint'(w[30:0]);
  endfunction

  function automatic logic [31:0] stored(input logic [31:0] w);
`ifdef NN_OUT_RELU_EN
    return w[31] ? 32'h0 : w;
`else
    return w;
`endif
  endfunction

  task automatic send_frame(input int maxgap);
    for (int i = 0; i < FRAME; i++) begin
      int gaps;
      gaps = (maxgap > 0) ? int'($urandom_range(maxgap, 0)) : 0;
      repeat (gaps) tick();
      check("in_ready_collect", in_ready, 1'b1);
      in_valid = 1'b1;
      in_data  = frame_w[i];
      tick();
      in_valid = 1'b0;
      if (i < FRAME - 1) check("no_early_valid", out_valid, 1'b0);
    end
    check("first_beat_latency", out_valid, 1'b1);
  endtask

  // Consumes replay + summary; optional stall at hold_at, overflow pulse at cycle ovf_at,
  // reset after rst_after accepted beats.
  task automatic drain(input int ready_pct, input int hold_at, input int ovf_at, input int rst_after);
    logic [31:0] exp_w [FRAME];
    int best, b, cyc, hold;
    best = 0;
    for (int i = 0; i < FRAME; i++) begin
      exp_w[i] = stored(frame_w[i]);
      if (fval(exp_w[i]) > fval(exp_w[best])) best = i;
    end
    b = 0; cyc = 0; hold = 0;
    while (b <= FRAME && cyc < 400) begin
      if (rst_after >= 0 && b == rst_after) begin
        rst = 1'b1;
        tick();
        rst = 1'b0;
        exp_ovf = 1'b0;
        check("rst_out_valid", out_valid, 1'b0);
        check("rst_overflow", overflow, 1'b0);
        check("rst_in_ready", in_ready, 1'b1);
        check("rst_out_data", out_data, 32'h0);
        return;
      end
      check("beat_valid", out_valid, 1'b1);
      check("drain_in_ready", in_ready, 1'b0);
      if (b < FRAME) begin
        check("beat_data", out_data, exp_w[b]);
        check("beat_idx", out_idx, b);
        check("beat_last", out_last, 1'b0);
      end else begin
        check("sum_data", out_data, exp_w[best]);
        check("sum_idx", out_idx, best);
        check("sum_last", out_last, 1'b1);
      end
      if (b == hold_at && hold < 3) begin
        out_ready = 1'b0;
        hold++;
      end else begin
        out_ready = ($urandom % 100) < ready_pct;
      end
      in_valid = (cyc == ovf_at);
      in_data  = 32'h3F800000;
      if (in_valid) exp_ovf = 1'b1;
      tick();
      in_valid = 1'b0;
      if (out_ready) b++;
      out_ready = 1'b0;
      cyc++;
    end
    if (cyc >= 400) check("drain_timeout", 1'b0, 1'b1);
    check("post_sum_idle", out_valid, 1'b0);
    check("post_sum_in_ready", in_ready, 1'b1);
    check("overflow_flag", overflow, exp_ovf);
  endtask

  initial begin
    logic [31:0] basic [FRAME];
    logic [31:0] negtie [FRAME];
    basic  = '{32'h3F800000, 32'h40000000, 32'h40400000, 32'h40800000, 32'h40A00000,
               32'h40C00000, 32'h40E00000, 32'h41000000, 32'h41100000};
    negtie = '{32'hC0400000, 32'hBF800000, 32'h80000000, 32'h00000000, 32'hC0000000,
               32'h40A00000, 32'h40A00000, 32'hC0E00000, 32'h3F800000};
    rst = 1'b1; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
    tick(); tick();
    rst = 1'b0;
    check("reset_out_valid", out_valid, 1'b0);
    check("reset_out_data", out_data, 32'h0);
    check("reset_out_idx", out_idx, 4'h0);
    check("reset_out_last", out_last, 1'b0);
    check("reset_overflow", overflow, 1'b0);
    check("reset_in_ready", in_ready, 1'b1);

    frame_w = basic;
    send_frame(0);
    drain(100, -1, -1, -1);

    frame_w = negtie;
    send_frame(0);
    drain(100, -1, -1, -1);

    frame_w = basic;
    send_frame(0);
    drain(100, 4, -1, -1);

    frame_w = negtie;
    send_frame(1);
    drain(100, -1, 2, -1);
    frame_w = basic;
    send_frame(0);
    drain(100, -1, -1, -1);
    check("overflow_sticky", overflow, 1'b1);

    send_frame(0);
    drain(100, -1, -1, 3);
    send_frame(0);
    drain(100, -1, -1, -1);

    for (int i = 0; i < FRAME; i++) frame_w[i] = {1'b1, 31'(fval(basic[FRAME-1-i]))};
    send_frame(4);
    drain(70, -1, -1, -1);

    for (int f = 0; f < 12; f++) begin
      for (int i = 0; i < FRAME; i++) begin
        if (i > 0 && ($urandom % 4) == 0) frame_w[i] = frame_w[$urandom_range(i - 1, 0)];
        else if (($urandom % 8) == 0) frame_w[i] = ($urandom % 2) ? 32'h80000000 : 32'h0;
        else frame_w[i] = {1'($urandom), 8'($urandom_range(140, 110)), 23'($urandom)};
      end
      send_frame(int'($urandom_range(3, 0)));
      drain(int'($urandom_range(90, 40)), int'($urandom_range(FRAME, 0)),
            (($urandom % 3) == 0) ? int'($urandom_range(12, 0)) : -1,
            (f == 7) ? int'($urandom_range(FRAME - 1, 0)) : -1);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end

endmodule

// File: doc/nn_out_collector.md
Name: nn_out_collector

Overview:
- Downstream stage of the NN core. Captures the fp32 result stream that NN emits on out_valid/out into a frame buffer.
- Once a frame is complete, replays the frame to a consumer over a valid/ready handshake, then emits one summary beat carrying the maximum value and its index (argmax).
- Used for result readout and classification in the NN datapath.

Parameters:
WIDTH, 32, data word width (IEEE-754 single: sign 1, exp 8, sig 23)
FRAME, 9, words per frame
IDX_W, 4, index width; must satisfy 2^IDX_W >= FRAME

Ports:
clk  input  1  clock, all logic on rising edge
rst  input  1  synchronous, active-high reset
in_valid  input  1  word present on in_data; driven from NN out_valid
in_data  input  WIDTH  fp32 word; driven from NN out
in_ready  output  1  high while in COLLECT state
out_valid  output  1  output beat present
out_ready  input  1  consumer accepts beat
out_data  output  WIDTH  replayed word, or max value on summary beat
out_idx  output  IDX_W  index of the current word, or argmax on summary beat
out_last  output  1  high on summary beat only
overflow  output  1  sticky error flag

Behaviour:
- Reset (rst sampled high at a clk edge)
  - State COLLECT; wr_cnt=0, rd_ptr=0.
  - out_valid=0, out_data=0, out_idx=0, out_last=0, overflow=0.
  - Max tracker invalid.
  - Reset mid-frame or mid-drain discards all buffered data; no partial output.
- States
  - COLLECT: in_ready=1, out_valid=0.
    - Each cycle with in_valid=1: write word to buf[wr_cnt], update max tracker, wr_cnt++.
    - When the word at wr_cnt==FRAME-1 is captured: next state DRAIN, wr_cnt=0.
    - in_valid gaps are allowed and do not reset wr_cnt.
  - DRAIN: in_ready=0, out_valid=1, out_data=buf[rd_ptr], out_idx=rd_ptr, out_last=0.
    - On out_valid&out_ready: rd_ptr++.
    - Handshake at rd_ptr==FRAME-1: next state SUMMARY, rd_ptr=0.
    - out_data and out_idx are held stable while out_ready=0.
  - SUMMARY: out_valid=1, out_last=1, out_data=max value, out_idx=argmax.
    - On handshake: next state COLLECT, max tracker cleared.
- Latency: first DRAIN beat is valid in the cycle after the clock edge that captures the last frame word. No combinational path from in_* to out_*.
- Max compare uses a sign-magnitude ordering key:
  - Normalise -0 (0x80000000) to +0 before compare.
  - key = sign ? ~word : word ^ 0x80000000; compare keys unsigned.
  - Strict greater-than replaces the current max, so ties keep the lowest index.
  - The first word of a frame always loads the tracker.
  - NaN/Inf are not expected from NN; ordering for them is the key order above, with no special handling.
- Stored and replayed words are bit-exact as received. The -0 normalisation applies only to compare, except as stated under the optional feature.
- Overflow:
  - in_valid=1 while not in COLLECT sets overflow=1 (sticky until rst). The word is dropped.
  - Same-cycle cases: in_valid on the transition cycle into COLLECT (the SUMMARY handshake cycle) is still in SUMMARY, so it is dropped and flagged.
- Buffer: FRAME x WIDTH register array; no memory macro.

Optional Feature:
NN_OUT_RELU_EN
- Defined: each captured word with sign=1 (including -0) is replaced by +0 (0x00000000) before storage and compare. The replay and summary then reflect post-ReLU values; an all-negative frame gives max=0, argmax=0.
- Undefined: words are stored unmodified, as described in Behaviour.

Test Plan:
- Basic frame: rst; 9 contiguous words 1.0 (0x3F800000) through 9.0 (0x41100000), out_ready=1 -> 9 beats identical to input, idx 0..8; summary out_data=0x41100000, out_idx=8, out_last=1; first out_valid one cycle after the 9th capture.
- Negatives and tie: words -3.0, -1.0, 0x80000000, +0, -2.0, 5.0, 5.0, -7.0, 1.0 -> summary 5.0 (0x40A00000), idx=5. With NN_OUT_RELU_EN, replay shows all negatives as 0x00000000, summary unchanged.
- Backpressure: out_ready low for 3 cycles at beat idx=4 -> out_data/out_idx held at buf[4]/4; no beat lost or duplicated; summary follows the 9th handshake.
- Overflow: in_valid pulse with 0x3F800000 during DRAIN -> overflow=1 persists; the replayed frame is unaltered; the next frame collects normally.
- Reset mid-drain: rst after 3 beats -> out_valid=0 next cycle, overflow=0, in_ready=1; a fresh frame of 9 words drains from idx 0.
- Gapped input: 9 words with random 0-4 cycle gaps, all negative (-9.0..-1.0 in order) -> max -1.0 (0xBF800000), idx=8.
